// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetcher and memory-controller signal bundle for icache
interface icache_if;
    logic        in_from_insFetcher_valid;
    logic [31:0] in_from_insFetcher_addr;
    logic        out_to_insFetcher_hit;
    logic [31:0] out_to_insFetcher_ins;
    logic        out_to_memCtrl_valid;
    logic [31:0] out_to_memCtrl_addr;
    logic        in_from_memCtrl_valid;
    logic [31:0] in_from_memCtrl_ins;

    modport slave (
        input  in_from_insFetcher_valid,
        input  in_from_insFetcher_addr,
        output out_to_insFetcher_hit,
        output out_to_insFetcher_ins,
        output out_to_memCtrl_valid,
        output out_to_memCtrl_addr,
        input  in_from_memCtrl_valid,
        input  in_from_memCtrl_ins
    );

    modport master (
        output in_from_insFetcher_valid,
        output in_from_insFetcher_addr,
        input  out_to_insFetcher_hit,
        input  out_to_insFetcher_ins,
        input  out_to_memCtrl_valid,
        input  out_to_memCtrl_addr,
        output in_from_memCtrl_valid,
        output in_from_memCtrl_ins
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with single outstanding refill
module icache #(
    parameter int ICACHE_LINES = 256,
    parameter int INDEX_WIDTH  = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_next;

    logic [ICACHE_LINES-1:0] valid;
    logic [TAG_WIDTH-1:0]    tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [31:0] miss_addr;
    logic        mem_req;

    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic [TAG_WIDTH-1:0]   miss_tag;
    logic                   line_match;
    logic                   start_miss;
    logic                   fill;

    assign req_index  = bus.in_from_insFetcher_addr[INDEX_WIDTH+1:2];
    assign req_tag    = bus.in_from_insFetcher_addr[31:INDEX_WIDTH+2];
    assign miss_index = miss_addr[INDEX_WIDTH+1:2];
    assign miss_tag   = miss_addr[31:INDEX_WIDTH+2];

    assign line_match = valid[req_index] && (tag_mem[req_index] == req_tag);

    assign bus.out_to_insFetcher_hit = rdy && (state == IDLE) &&
                                       bus.in_from_insFetcher_valid && line_match;
    assign bus.out_to_insFetcher_ins = data_mem[req_index];
    // miss_addr doubles as the registered refill address seen by the memory controller
    assign bus.out_to_memCtrl_valid  = mem_req;
    assign bus.out_to_memCtrl_addr   = miss_addr;

    always_comb begin
        state_next = state;
        start_miss = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (rdy && bus.in_from_insFetcher_valid && !line_match) begin
                    start_miss = 1'b1;
                    state_next = MISS;
                end
            end
            MISS: begin
                if (rdy && bus.in_from_memCtrl_valid) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            miss_addr <= '0;
        end else begin
            state <= state_next;
            if (start_miss) begin
                mem_req   <= 1'b1;
                miss_addr <= bus.in_from_insFetcher_addr;
            end else if (fill) begin
                mem_req           <= 1'b0;
                valid[miss_index] <= 1'b1;
            end
        end
    end

    // tag and data arrays carry no reset; valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= bus.in_from_memCtrl_ins;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scenario and randomized checks of icache against a line-table model
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    logic        fv = 1'b0;
    logic [31:0] fa = '0;
    logic        mv = 1'b0;
    logic [31:0] mi = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    icache_if bus();

    assign bus.in_from_insFetcher_valid = fv;
    assign bus.in_from_insFetcher_addr  = fa;
    assign bus.in_from_memCtrl_valid    = mv;
    assign bus.in_from_memCtrl_ins      = mi;

    icache #(.ICACHE_LINES(256), .INDEX_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as seen by the memory controller
    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Reference model: each line remembers the full address it holds
    bit          line_ok   [256];
    logic [31:0] line_addr [256];
    bit          m_busy = 1'b0;
    logic [31:0] m_pend = '0;

    function automatic bit model_has(input logic [31:0] a);
        return line_ok[a[9:2]] && (line_addr[a[9:2]] == a);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_pend = '0;
            for (int i = 0; i < 256; i++) line_ok[i] = 1'b0;
        end else if (rdy) begin
            if (!m_busy) begin
                if (fv && !model_has(fa)) begin
                    m_busy = 1'b1;
                    m_pend = fa;
                end
            end else if (mv) begin
                line_ok[m_pend[9:2]]   = 1'b1;
                line_addr[m_pend[9:2]] = m_pend;
                m_busy = 1'b0;
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic m);
        @(negedge clk);
        fv = v;
        fa = a;
        mv = m;
        mi = ins_of(m_pend);
        #1;
    endtask

    task automatic fill_line(input logic [31:0] a);
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, a, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; fv = 1'b1; fa = 32'h0; mv = 1'b0;
        #1;
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", bus.out_to_memCtrl_valid); end
        n_cmp++; if (bus.out_to_memCtrl_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.out_to_memCtrl_addr); end
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", bus.out_to_insFetcher_hit); end
        @(negedge clk);
        fv = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_first_miss;
        cyc(1'b1, 32'h0, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL first_T_hit got %b want 0", bus.out_to_insFetcher_hit); end
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL first_T_memv got %b want 0", bus.out_to_memCtrl_valid); end
        cyc(1'b1, 32'h0, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b1) begin n_fail++; $display("FAIL first_T1_memv got %b want 1", bus.out_to_memCtrl_valid); end
        n_cmp++; if (bus.out_to_memCtrl_addr !== 32'h0) begin n_fail++; $display("FAIL first_T1_addr got %h want 0", bus.out_to_memCtrl_addr); end
        cyc(1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h0, 1'b1);
        n_cmp++; if (mi !== 32'h0000_0013) begin n_fail++; $display("FAIL first_resp_data got %h want 00000013", mi); end
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b1) begin n_fail++; $display("FAIL first_T3_memv got %b want 1", bus.out_to_memCtrl_valid); end
        cyc(1'b1, 32'h0, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL first_T4_hit got %b want 1", bus.out_to_insFetcher_hit); end
        n_cmp++; if (bus.out_to_insFetcher_ins !== 32'h0000_0013) begin n_fail++; $display("FAIL first_T4_ins got %h want 00000013", bus.out_to_insFetcher_ins); end
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL first_T4_memv got %b want 0", bus.out_to_memCtrl_valid); end
    endtask

    task automatic test_hit_after_fill;
        fill_line(32'h4);
        cyc(1'b1, 32'h4, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL refetch_hit got %b want 1", bus.out_to_insFetcher_hit); end
        n_cmp++; if (bus.out_to_insFetcher_ins !== ins_of(32'h4)) begin n_fail++; $display("FAIL refetch_ins got %h want %h", bus.out_to_insFetcher_ins, ins_of(32'h4)); end
        cyc(1'b1, 32'h4, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL refetch2_hit got %b want 1", bus.out_to_insFetcher_hit); end
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL refetch_no_req got %b want 0", bus.out_to_memCtrl_valid); end
    endtask

    task automatic test_conflict;
        fill_line(32'h8);
        cyc(1'b1, 32'h8, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL conflict_a_hit got %b want 1", bus.out_to_insFetcher_hit); end
        cyc(1'b1, 32'h408, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL conflict_b_hit got %b want 0", bus.out_to_insFetcher_hit); end
        cyc(1'b1, 32'h408, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_addr !== 32'h408) begin n_fail++; $display("FAIL conflict_b_addr got %h want 00000408", bus.out_to_memCtrl_addr); end
        cyc(1'b1, 32'h408, 1'b1);
        cyc(1'b1, 32'h408, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_ins !== ins_of(32'h408) || bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL conflict_b_fill got hit=%b ins=%h want hit=1 ins=%h", bus.out_to_insFetcher_hit, bus.out_to_insFetcher_ins, ins_of(32'h408)); end
        cyc(1'b1, 32'h8, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL conflict_a_evicted got %b want 0", bus.out_to_insFetcher_hit); end
        cyc(1'b1, 32'h8, 1'b1);
    endtask

    task automatic test_jump_during_miss;
        cyc(1'b1, 32'h10, 1'b0);
        cyc(1'b1, 32'h20, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_addr !== 32'h10 || bus.out_to_memCtrl_valid !== 1'b1) begin n_fail++; $display("FAIL jump_addr got v=%b a=%h want v=1 a=00000010", bus.out_to_memCtrl_valid, bus.out_to_memCtrl_addr); end
        cyc(1'b1, 32'h20, 1'b1);
        cyc(1'b1, 32'h20, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0 || bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL jump_new_miss got hit=%b memv=%b want 0 0", bus.out_to_insFetcher_hit, bus.out_to_memCtrl_valid); end
        cyc(1'b1, 32'h20, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_addr !== 32'h20) begin n_fail++; $display("FAIL jump_new_addr got %h want 00000020", bus.out_to_memCtrl_addr); end
        cyc(1'b1, 32'h20, 1'b1);
        cyc(1'b1, 32'h10, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1 || bus.out_to_insFetcher_ins !== ins_of(32'h10)) begin n_fail++; $display("FAIL jump_old_hit got hit=%b ins=%h want hit=1 ins=%h", bus.out_to_insFetcher_hit, bus.out_to_insFetcher_ins, ins_of(32'h10)); end
    endtask

    task automatic test_rdy_freeze;
        cyc(1'b1, 32'h30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdy = 1'b0; fv = 1'b1; fa = 32'h4; mv = 1'b0;
            #1;
            n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL freeze_hit[%0d] got %b want 0", i, bus.out_to_insFetcher_hit); end
            n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b1 || bus.out_to_memCtrl_addr !== 32'h30) begin n_fail++; $display("FAIL freeze_req[%0d] got v=%b a=%h want v=1 a=00000030", i, bus.out_to_memCtrl_valid, bus.out_to_memCtrl_addr); end
        end
        @(negedge clk);
        rdy = 1'b1;
        cyc(1'b1, 32'h30, 1'b1);
        cyc(1'b1, 32'h30, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1 || bus.out_to_insFetcher_ins !== ins_of(32'h30)) begin n_fail++; $display("FAIL freeze_resume got hit=%b ins=%h want hit=1 ins=%h", bus.out_to_insFetcher_hit, bus.out_to_insFetcher_ins, ins_of(32'h30)); end
        @(negedge clk);
        rdy = 1'b0; fv = 1'b1; fa = 32'h4;
        #1;
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0) begin n_fail++; $display("FAIL idle_rdy0_hit got %b want 0", bus.out_to_insFetcher_hit); end
        @(negedge clk);
        rdy = 1'b1; fa = 32'h44;
        #1;
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rdy0_noreq got %b want 0", bus.out_to_memCtrl_valid); end
        cyc(1'b1, 32'h44, 1'b1);
    endtask

    task automatic test_reset_mid_miss;
        cyc(1'b1, 32'h4, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b1) begin n_fail++; $display("FAIL prereset_hit got %b want 1", bus.out_to_insFetcher_hit); end
        cyc(1'b1, 32'h50, 1'b0);
        cyc(1'b1, 32'h50, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b1) begin n_fail++; $display("FAIL premid_memv got %b want 1", bus.out_to_memCtrl_valid); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b0 || bus.out_to_memCtrl_addr !== 32'h0) begin n_fail++; $display("FAIL async_reset got v=%b a=%h want v=0 a=0", bus.out_to_memCtrl_valid, bus.out_to_memCtrl_addr); end
        @(negedge clk);
        rst = 1'b1; fv = 1'b0; mv = 1'b1; mi = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h4, 1'b0);
        n_cmp++; if (bus.out_to_insFetcher_hit !== 1'b0 || bus.out_to_memCtrl_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_miss got hit=%b memv=%b want 0 0", bus.out_to_insFetcher_hit, bus.out_to_memCtrl_valid); end
        cyc(1'b1, 32'h4, 1'b0);
        n_cmp++; if (bus.out_to_memCtrl_valid !== 1'b1 || bus.out_to_memCtrl_addr !== 32'h4) begin n_fail++; $display("FAIL postreset_req got v=%b a=%h want v=1 a=00000004", bus.out_to_memCtrl_valid, bus.out_to_memCtrl_addr); end
        cyc(1'b1, 32'h4, 1'b1);
    endtask

    task automatic test_random;
        logic exp_hit;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rdy = ($urandom_range(7) != 0);
            fv  = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) fa = {$urandom} & 32'hFFFF_FFFC;
            else fa = ($urandom_range(1) << 10) | ($urandom_range(7) << 2);
            if (!rdy) mv = 1'b0;
            else if (m_busy) mv = ($urandom_range(2) == 0);
            else mv = ($urandom_range(9) == 0);
            mi = ins_of(m_pend);
            #1;
            exp_hit = rdy && !m_busy && fv && model_has(fa);
            n_cmp++; if (bus.out_to_insFetcher_hit !== exp_hit) begin n_fail++; $display("FAIL rnd_hit[%0d] addr=%h got %b want %b", i, fa, bus.out_to_insFetcher_hit, exp_hit); end
            if (exp_hit) begin
                n_cmp++; if (bus.out_to_insFetcher_ins !== ins_of(fa)) begin n_fail++; $display("FAIL rnd_ins[%0d] addr=%h got %h want %h", i, fa, bus.out_to_insFetcher_ins, ins_of(fa)); end
            end
            n_cmp++; if (bus.out_to_memCtrl_valid !== m_busy) begin n_fail++; $display("FAIL rnd_memv[%0d] got %b want %b", i, bus.out_to_memCtrl_valid, m_busy); end
            n_cmp++; if (bus.out_to_memCtrl_addr !== m_pend) begin n_fail++; $display("FAIL rnd_memaddr[%0d] got %h want %h", i, bus.out_to_memCtrl_addr, m_pend); end
        end
    endtask

    initial begin
        test_reset;
        test_first_miss;
        test_hit_after_fill;
        test_conflict;
        test_jump_during_miss;
        test_rdy_freeze;
        test_reset_mid_miss;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction fetcher and the memory controller. Answers fetcher lookups combinationally in the same cycle. On a miss it issues one 32-bit word request to the memory controller, holds it until the response arrives, then writes the line. The fetcher keeps its request asserted until it sees a hit.

## Interface
Parameters:
- ICACHE_LINES, 256: number of lines, one 32-bit instruction per line; must be a power of two.
- INDEX_WIDTH, 8: log2(ICACHE_LINES).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global run enable; low freezes the block.
- in_from_insFetcher_valid  input  1  lookup request.
- in_from_insFetcher_addr  input  32  instruction address; bits [1:0] are 0.
- out_to_insFetcher_hit  output  1  the instruction for the current address is valid this cycle.
- out_to_insFetcher_ins  output  32  instruction word; defined only when hit=1.
- out_to_memCtrl_valid  output  1  refill request, registered.
- out_to_memCtrl_addr  output  32  refill word address, registered.
- in_from_memCtrl_valid  input  1  refill data valid; one-cycle pulse.
- in_from_memCtrl_ins  input  32  refill data.

## Operation
- Address split:
  - index = addr[INDEX_WIDTH+1:2]
  - tag = addr[31:INDEX_WIDTH+2], 22 bits at default.
- Storage:
  - valid[ICACHE_LINES] in flops with asynchronous reset.
  - tag[] and data[] arrays with no reset.
- Hit logic, combinational: hit = rdy & state==IDLE & in_from_insFetcher_valid & valid[index] & tag[index]==tag. The ins output is data[index].
- FSM states are IDLE and MISS.
- IDLE:
  - Request valid and not hit, with rdy=1: latch addr into miss_addr.
  - Set out_to_memCtrl_valid=1 and out_to_memCtrl_addr=addr on the same edge.
  - Go to MISS.
- MISS:
  - Hold out_to_memCtrl_valid=1 and the address stable.
  - On an edge with in_from_memCtrl_valid=1 and rdy=1, write the arrays at miss_addr: data=in_from_memCtrl_ins, tag, valid=1.
  - On that same edge, drop out_to_memCtrl_valid to 0 and return to IDLE.
  - The fetcher's request inputs are ignored while in MISS.
- A fetcher address change during MISS (e.g. a jump) does not abort the refill. Instruction memory is immutable, so the line is filled anyway. The new address is looked up on the first IDLE cycle.
- Only one outstanding refill at a time; no hit-under-miss.
- Lines are never invalidated except by reset. Replacement overwrites the indexed line unconditionally.
- rdy=0:
  - hit is forced to 0.
  - FSM, arrays and memory-side outputs hold.
  - The memory controller is frozen by the same rdy and does not pulse valid while rdy=0.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE
  - all valid bits 0
  - out_to_memCtrl_valid=0, out_to_memCtrl_addr=0
  - hit=0, ins=don't-care (data array is unreset)
- Release of rst is synchronous to clk. Reset asserted mid-MISS abandons the refill. A late memCtrl response after reset is ignored, because state is IDLE.
- Hit latency: 0 cycles (same cycle as request).
- Miss, request in cycle T:
  - T: hit=0.
  - T+1: out_to_memCtrl_valid=1.
  - Response in cycle R ≥ T+1: line written at the end of R; out_to_memCtrl_valid=0 and state IDLE in R+1.
  - R+1: hit=1 if the fetcher still presents the same address.
- A response pulse arriving in IDLE is ignored.
- Two addresses with the same index and different tags thrash. Each access is a full miss, with no deadlock.

## Test plan
- After reset, request addr 0x0000_0000 → hit=0 in T; memCtrl_valid=1 with addr 0x0 at T+1. Respond at T+3 with 0x0000_0013 → hit=1 and ins=0x0000_0013 at T+4; memCtrl_valid=0 at T+4.
- Fill 0x0000_0004, then re-request it → hit=1 in the same cycle, no memCtrl request.
- Conflict: fill 0x0000_0008, then request 0x0000_0408 (same index 2, different tag) → miss, refill. Then 0x0000_0008 misses again.
- During MISS for 0x10, the fetcher switches to 0x20 → refill completes for 0x10 (memCtrl_addr stays 0x10). Next cycle 0x20 misses. A later 0x10 request hits.
- rdy=0 for 3 cycles while in MISS with a hit-able address present → hit=0, memCtrl_valid held at 1, no array write. Normal completion resumes after rdy=1.
- Assert rst=0 mid-MISS, then a memCtrl pulse → memCtrl_valid=0 immediately (asynchronous). All lines invalid: a previously filled address misses.
